// File: rtl/cell_serializer_pkg.sv
// Shared definitions for the cell serializer.
//   state_e      : FSM state encoding (idle / shifting a word)
//   DefaultWidth : default word width
//   DefaultCntW  : default bit-counter width, ceil(log2(DefaultWidth))
package cell_serializer_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StShift = 1'b1
    } state_e;

    localparam int unsigned DefaultWidth = 8;
    localparam int unsigned DefaultCntW  = 3;

endpackage

// File: rtl/cell_shift_stage.sv
// One bit slice of the serializer shift register: a 2:1 mux selecting the
// parallel load bit over the shift-in bit, feeding a register cell with hold.
//   clk      : clock
//   rst      : asynchronous active-low reset, clears the cell
//   load     : capture load_bit (takes priority over shift_en)
//   shift_en : capture shift_in
//   load_bit : parallel data bit
//   shift_in : bit from the next-higher slice
//   q        : stored bit
module cell_shift_stage (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic shift_en,
    input  logic load_bit,
    input  logic shift_in,
    output logic q
);

    logic mux_out;
    logic d;

    assign mux_out = load ? load_bit : shift_in;

    always_comb begin
        d = q;
        if (load || shift_en) begin
            d = mux_out;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/cell_serializer.sv
// Parallel-in / serial-out transmitter. Accepts a WIDTH-bit word on a
// valid/ready handshake and shifts it out LSB-first, one bit per clock, with
// gapless back-to-back words when in_valid is held.
//   clk       : clock
//   rst       : asynchronous active-low reset
//   in_valid  : in_data holds a word to send
//   in_ready  : word can be accepted this cycle
//   in_data   : parallel word, sampled only on handshake
//   ser_out   : current serial bit
//   ser_valid : ser_out carries a live bit
//   ser_first : bit 0 of a word is on ser_out
//   ser_last  : bit WIDTH-1 of a word is on ser_out
//   busy      : a word is in flight (same as ser_valid)
module cell_serializer
    import cell_serializer_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth,
    parameter int unsigned CNT_W = DefaultCntW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             ser_first,
    output logic             ser_last,
    output logic             busy
);

    localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] carry;
    logic             cnt_last;
    logic             accept;
    logic             load;
    logic             shift_en;
    logic [WIDTH-1:0] load_word;
    logic [WIDTH-1:0] shreg;

    // Counter increment as a ripple of half adders (carry-in of 1).
    assign carry[0] = 1'b1;
    for (genvar i = 0; i < CNT_W; i++) begin : g_ha
        assign cnt_inc[i] = cnt_q[i] ^ carry[i];
        if (i < CNT_W - 1) begin : g_carry
            assign carry[i+1] = cnt_q[i] & carry[i];
        end
    end

    // Bitwise equality against WIDTH-1 reduced by an AND tree.
    assign cnt_last = &(cnt_q ~^ LastCnt);

    // Gated by rst so in_ready is low throughout reset, not just after it.
    assign in_ready = rst & ((state_q == StIdle) | ((state_q == StShift) & cnt_last));
    assign accept   = in_valid & in_ready;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        load      = 1'b0;
        shift_en  = 1'b0;
        load_word = '0;
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d   = StShift;
                    cnt_d     = '0;
                    load      = 1'b1;
                    load_word = in_data;
                end
            end
            StShift: begin
                if (!cnt_last) begin
                    shift_en = 1'b1;
                    cnt_d    = cnt_inc;
                end else if (accept) begin
                    // Gapless reload: next word's bit 0 follows this bit directly.
                    cnt_d     = '0;
                    load      = 1'b1;
                    load_word = in_data;
                end else begin
                    // Return to idle with the shift register cleared (load of zero).
                    state_d = StIdle;
                    cnt_d   = '0;
                    load    = 1'b1;
                end
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_stage
        logic shift_in;
        if (i == WIDTH - 1) begin : g_top
            assign shift_in = 1'b0;
        end else begin : g_mid
            assign shift_in = shreg[i+1];
        end

        cell_shift_stage u_stage (
            .clk      (clk),
            .rst      (rst),
            .load     (load),
            .shift_en (shift_en),
            .load_bit (load_word[i]),
            .shift_in (shift_in),
            .q        (shreg[i])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ser_valid = (state_q == StShift);
    assign busy      = ser_valid;
    assign ser_out   = ser_valid & shreg[0];
    assign ser_first = ser_valid & (cnt_q == '0);
    assign ser_last  = ser_valid & cnt_last;

endmodule

// File: tb/tb_cell_serializer.sv
module tb_cell_serializer;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       e_rdy;
        logic       e_vld;
        logic       e_out;
        logic       e_fst;
        logic       e_lst;
    } vec_t;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       ser_out, ser_valid, ser_first, ser_last, busy;

    logic       v2;
    logic       r2;
    logic [1:0] d2;
    logic       o2, sv2, f2, l2, b2;

    int checks = 0;
    int errors = 0;

    vec_t vecs[$];
    vec_t vecs2[$];

    cell_serializer #(
        .WIDTH (8),
        .CNT_W (3)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .ser_out   (ser_out),
        .ser_valid (ser_valid),
        .ser_first (ser_first),
        .ser_last  (ser_last),
        .busy      (busy)
    );

    cell_serializer #(
        .WIDTH (2),
        .CNT_W (1)
    ) u_dut2 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (v2),
        .in_ready  (r2),
        .in_data   (d2),
        .ser_out   (o2),
        .ser_valid (sv2),
        .ser_first (f2),
        .ser_last  (l2),
        .busy      (b2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add_vec(input logic v, input logic [7:0] d, input logic rdy,
                           input logic vld, input logic o, input logic f, input logic l);
        vec_t e;
        e.v = v; e.d = d; e.e_rdy = rdy; e.e_vld = vld; e.e_out = o; e.e_fst = f; e.e_lst = l;
        vecs.push_back(e);
    endtask

    task automatic add_idle(input logic v, input logic [7:0] d);
        add_vec(v, d, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // Eight shifting cycles of word w; vm/dm driven on non-last cycles, vl/dl on the last.
    task automatic add_word(input logic [7:0] w, input logic vm, input logic [7:0] dm,
                            input logic vl, input logic [7:0] dl);
        for (int i = 0; i < 8; i++) begin
            add_vec((i == 7) ? vl : vm, (i == 7) ? dl : dm, (i == 7), 1'b1, w[i],
                    (i == 0), (i == 7));
        end
    endtask

    task automatic add_vec2(input logic v, input logic [1:0] d, input logic rdy,
                            input logic vld, input logic o, input logic f, input logic l);
        vec_t e;
        e.v = v; e.d = {6'd0, d}; e.e_rdy = rdy; e.e_vld = vld; e.e_out = o;
        e.e_fst = f; e.e_lst = l;
        vecs2.push_back(e);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_in_ready"}, in_ready, 0);
        chk({tag, "_ser_out"}, ser_out, 0);
        chk({tag, "_ser_valid"}, ser_valid, 0);
        chk({tag, "_ser_first"}, ser_first, 0);
        chk({tag, "_ser_last"}, ser_last, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [7:0] pend;
        logic       have;
        logic [1:0] exp_q[$];
        logic [1:0] eb;

        rst = 1'b0; in_valid = 1'b0; in_data = '0; v2 = 1'b0; d2 = '0;

        // Basic word, then back to idle.
        add_idle(1'b1, 8'hA5);
        add_word(8'hA5, 1'b0, 8'h00, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);
        // Held in_valid: A5 then 3C gapless.
        add_idle(1'b1, 8'hA5);
        add_word(8'hA5, 1'b1, 8'h3C, 1'b1, 8'h3C);
        add_word(8'h3C, 1'b0, 8'h00, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);
        // FF presented mid-word waits for the last cycle, then follows directly.
        add_idle(1'b1, 8'h5A);
        add_word(8'h5A, 1'b1, 8'hFF, 1'b1, 8'hFF);
        add_word(8'hFF, 1'b0, 8'h00, 1'b0, 8'h00);
        add_idle(1'b0, 8'h00);
        // Valid withdrawn before the last cycle: nothing accepted, return to idle.
        add_idle(1'b1, 8'h81);
        add_word(8'h81, 1'b1, 8'h77, 1'b0, 8'h77);
        add_idle(1'b0, 8'h00);
        add_idle(1'b0, 8'h00);

        // WIDTH=2: 0x2 then 0x1 back-to-back -> 0,1,1,0.
        add_vec2(1'b1, 2'h2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        add_vec2(1'b1, 2'h1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        add_vec2(1'b1, 2'h1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        add_vec2(1'b0, 2'h0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        add_vec2(1'b0, 2'h0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        add_vec2(1'b0, 2'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

        #12;
        chk_all_zero("reset");
        chk("reset_w2_ready", r2, 0);
        chk("reset_w2_valid", sv2, 0);

        @(negedge clk);
        rst = 1'b1;

        foreach (vecs[k]) begin
            @(negedge clk);
            in_valid = vecs[k].v;
            in_data  = vecs[k].d;
            #1;
            chk("vec_in_ready", in_ready, vecs[k].e_rdy);
            chk("vec_ser_valid", ser_valid, vecs[k].e_vld);
            chk("vec_busy", busy, vecs[k].e_vld);
            chk("vec_ser_out", ser_out, vecs[k].e_out);
            chk("vec_ser_first", ser_first, vecs[k].e_fst);
            chk("vec_ser_last", ser_last, vecs[k].e_lst);
        end

        // Reset in the middle of 0x0F at counter 4.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h0F;
        #1 chk("rst_mid_accept_ready", in_ready, 1);
        @(negedge clk);
        in_valid = 1'b0; in_data = 8'h00;
        repeat (4) @(negedge clk);
        #1;
        chk("rst_mid_valid_before", ser_valid, 1);
        chk("rst_mid_first_before", ser_first, 0);
        #2 rst = 1'b0;
        in_valid = 1'b1; in_data = 8'hC3;
        #1 chk_all_zero("rst_mid_async");
        @(negedge clk);
        #1 chk_all_zero("rst_mid_held");
        in_valid = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("rst_after_valid", ser_valid, 0);
            chk("rst_after_ready", in_ready, 1);
        end

        // WIDTH=2 instance.
        foreach (vecs2[k]) begin
            @(negedge clk);
            v2 = vecs2[k].v;
            d2 = vecs2[k].d[1:0];
            #1;
            chk("w2_in_ready", r2, vecs2[k].e_rdy);
            chk("w2_ser_valid", sv2, vecs2[k].e_vld);
            chk("w2_ser_out", o2, vecs2[k].e_out);
            chk("w2_ser_first", f2, vecs2[k].e_fst);
            chk("w2_ser_last", l2, vecs2[k].e_lst);
        end

        // Random gaps and withdrawals against a queue of expected {first, bit}.
        have = 1'b0;
        pend = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            #1;
            if (ser_valid) begin
                if (exp_q.size() == 0) begin
                    chk("rand_unexpected_bit", 1, 0);
                end else begin
                    eb = exp_q.pop_front();
                    chk("rand_ser_out", ser_out, eb[0]);
                    chk("rand_ser_first", ser_first, eb[1]);
                end
            end
            if (cyc < 360) begin
                if (!have && $urandom_range(0, 2) == 0) begin
                    have = 1'b1;
                    pend = 8'($urandom);
                end else if (have && !in_ready && $urandom_range(0, 7) == 0) begin
                    have = 1'b0;
                end
            end else begin
                have = 1'b0;
            end
            in_valid = have;
            in_data  = have ? pend : 8'($urandom);
            if (in_valid && in_ready) begin
                for (int i = 0; i < 8; i++) exp_q.push_back({(i == 0), pend[i]});
                have = 1'b0;
            end
        end
        chk("rand_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
